// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin burst arbiter driving a 3-input operand mux select.
// Define ARB_BURST_LOCK_EN to lock grants for BURST_LEN beats; otherwise each burst is one beat.
module mux_sel_arbiter #(
  parameter int BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       o_ready,
  output logic [1:0] sel,
  output logic [2:0] gnt,
  output logic       o_valid,
  output logic [2:0] ack,
  output logic       busy
);
`ifdef ARB_BURST_LOCK_EN
  localparam logic [3:0] LAST = 4'(BURST_LEN - 1);
`else
  localparam logic [3:0] LAST = 4'd0;
`endif
  typedef enum logic {IDLE, BUSY} state_t;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ptr_q, ptr_d, sel_q, sel_d, p1, p2, pick, cur;
  logic [2:0] gnt_q, gnt_d;
  logic       hold, xfer, done;
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return p == 2'd2 ? 2'd0 : p + 2'd1;
  endfunction
  assign p1      = nxt(ptr_q);
  assign p2      = nxt(p1);
  assign pick    = req[p1] ? p1 : req[p2] ? p2 : ptr_q;
  assign cur     = gnt_q[0] ? 2'd0 : gnt_q[1] ? 2'd1 : 2'd2;
  assign busy    = state_q == BUSY;
  assign hold    = |(req & gnt_q);
  assign o_valid = busy && hold;
  assign xfer    = o_valid && o_ready;
  assign ack     = xfer ? gnt_q : 3'b000;
  assign gnt     = gnt_q;
  assign sel     = sel_q;
  // a dropped request ends the burst without a transfer
  assign done    = busy && (!hold || (xfer && cnt_q == LAST));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    if (!busy && |req) begin
      state_d = BUSY;
      gnt_d   = 3'b001 << pick;
      sel_d   = pick == 2'd0 ? 2'b00 : pick == 2'd1 ? 2'b10 : 2'b11;
      cnt_d   = 4'd0;
    end else if (done) begin
      state_d = IDLE;
      ptr_d   = cur;
      gnt_d   = 3'b000;
    end else if (xfer) begin
      cnt_d = cnt_q + 4'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ptr_q   <= 2'd2;
      gnt_q   <= 3'b000;
      sel_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end
endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 The module SHALL have parameter BURST_LEN, default 4, giving the number of beats per grant; the legal range is 1..16.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port req, input, 3 bits: requests, where bit0 is operand source A, bit1 is B and bit2 is C.
REQ-005 The module SHALL have port o_ready, input, 1 bit: the downstream consumer accepts the current mux output.
REQ-006 The module SHALL have port sel, output, 2 bits: select code driven to the 3-input operand multiplexer.
REQ-007 The module SHALL have port gnt, output, 3 bits: one-hot current grant, or all-zero when idle.
REQ-008 The module SHALL have port o_valid, output, 1 bit: the mux output is valid this cycle.
REQ-009 The module SHALL have port ack, output, 3 bits: one-cycle pulse to the requester whose beat transferred.
REQ-010 The module SHALL have port busy, output, 1 bit: high while the FSM is in BUSY.

Function
REQ-011 The module SHALL use the sel encodings A=2'b00, B=2'b10 and C=2'b11; 2'b01 SHALL never be driven.
REQ-012 The FSM SHALL have exactly two states, IDLE and BUSY, with a 4-bit beat counter cnt and a 2-bit round-robin pointer ptr holding the last granted source.
REQ-013 In IDLE with any req bit set, the arbiter SHALL pick the first set request in order ptr+1, ptr+2, ptr (mod 3), register gnt and sel, clear cnt, and enter BUSY on the next edge.
REQ-014 In IDLE with req==0, the module SHALL hold gnt=0 and o_valid=0, and sel SHALL keep its last value.
REQ-015 In BUSY, o_valid SHALL be driven combinationally as (req & gnt) != 0.
REQ-016 A beat SHALL transfer when o_valid && o_ready; in that same cycle ack SHALL equal gnt (combinational pulse), else ack SHALL be 0.
REQ-017 On each transfer the module SHALL increment cnt; a transfer with cnt==BURST_LEN-1 SHALL end the burst.
REQ-018 The burst SHALL also end if the granted req bit is low in BUSY; that cycle SHALL produce no transfer and no ack.
REQ-019 On burst end, on the next edge the module SHALL return to IDLE, set ptr to the granted index and clear gnt.
REQ-020 Between consecutive bursts there SHALL be exactly one IDLE bubble cycle, so latency from req to o_valid is 1 cycle.
REQ-021 o_ready low SHALL stall without changing cnt, gnt or sel, with no timeout.
REQ-022 Request bits that change for non-granted sources during BUSY SHALL have no effect until the next IDLE arbitration.
REQ-023 At most one ack bit SHALL be high at any time, and gnt SHALL always be one-hot or zero.

Reset
REQ-024 While rst is high, the module SHALL hold state=IDLE, cnt=0, ptr=2 (so A has first priority), gnt=0, sel=2'b00, o_valid=0, ack=0 and busy=0.
REQ-025 Assertion of rst mid-burst SHALL abort the burst immediately, with no ack and no ptr update.

Configuration
REQ-026 When macro ARB_BURST_LOCK_EN is defined, grants SHALL be locked for up to BURST_LEN beats as specified above.
REQ-027 When ARB_BURST_LOCK_EN is undefined, BURST_LEN SHALL be ignored and treated as 1: every transfer ends the burst and re-arbitration occurs after one IDLE cycle.

Verification
REQ-028 After reset with req=3'b111 and o_ready=1, the bench SHALL check grant order A,B,C,A with sel 00,10,11,00, four acks per burst (lock on), and one bubble between bursts.
REQ-029 With req=3'b010 only and o_ready toggling 1,0,1,1,0,1, the bench SHALL check exactly 4 ack[1] pulses, no ack in o_ready=0 cycles, and cnt frozen during stalls.
REQ-030 With B granted, if req[1] drops after 2 beats, the bench SHALL check no further ack, return to IDLE, ptr=1, and that a pending C is granted next.
REQ-031 With rst pulsed high for 1 cycle during beat 3 of a C burst, the bench SHALL check that all outputs are zero/00 asynchronously and that the next grant with req=3'b100 goes to C with A first priority restored.
REQ-032 With ARB_BURST_LOCK_EN undefined and req=3'b101, the bench SHALL check alternation A,C,A,C with exactly one ack per grant.
